mult_a_seq: RTL and testbench

MULT_A_SEQ -- requirements
Module: mult_a_seq

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_a_row.sv | 16 +
 rtl/mult_a_seq.sv | 79 +++++++
 tb/tb_mult_a_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and types for the Baugh-Wooley multA/multB pipeline.
package mult_pkg;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned PIN_W = 10;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned P_W   = 12;

  localparam logic [PIN_W-1:0] BW_BIAS  = 10'd544;
  localparam logic [CNT_W-1:0] LAST_ROW = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  // Operand pair captured at accept and forwarded to multB.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;
endpackage

// File: rtl/mult_a_row.sv
// One Baugh-Wooley row: sign-extended multiplier shifted by the row index, gated by a multiplicand bit.
module mult_a_row
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]  b,
  input  logic             a_bit,
  input  logic [CNT_W-1:0] idx,
  output logic [PIN_W-1:0] row
);

  logic [PIN_W-1:0] b_ext;

  assign b_ext = {{(PIN_W - OP_W){b[OP_W-1]}}, b};
  assign row   = a_bit ? (b_ext << idx) : '0;

endmodule

// File: rtl/mult_a_seq.sv
// Sequential first stage of a 6x6 signed multiplier: accumulates rows 0..3 into a biased partial sum.
module mult_a_seq
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  a_out,
  output logic [OP_W-1:0]  b_out,
  output logic [PIN_W-1:0] pin
);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [PIN_W-1:0] acc, acc_d;
  op_pair_t         pair_d;
  logic [PIN_W-1:0] row;

  mult_a_row u_row (
    .b     (b_out),
    .a_bit (a_out[cnt]),
    .idx   (cnt),
    .row   (row)
  );

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      acc   <= acc_d;
      a_out <= pair_d.a;
      b_out <= pair_d.b;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    pair_d  = '{a: a_out, b: b_out};
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          pair_d  = '{a: a, b: b};
          acc_d   = BW_BIAS;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc + row;
        cnt_d = CNT_W'(cnt + 1'b1);
        if (cnt == LAST_ROW) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign pin       = acc;

endmodule

// File: tb/tb_mult_a_seq.sv
// Directed bench for mult_a_seq with a behavioural multB back end for product checks.
module tb_mult_a_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] a;
  logic [5:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] a_out;
  logic [5:0] b_out;
  logic [9:0] pin;

  int n_cmp = 0;
  int n_bad = 0;

  mult_a_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .pin       (pin)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] prod(input logic [5:0] x, input logic [5:0] y);
    int xi, yi;
    xi = $signed(x);
    yi = $signed(y);
    return 12'(xi * yi);
  endfunction

  // Remaining Baugh-Wooley rows 4 and 5 applied to the unbiased partial sum.
  function automatic logic [11:0] multb(input logic [5:0] x, input logic [5:0] y,
                                        input logic [9:0] p);
    int s, yi;
    yi = $signed(y);
    s  = int'(p) - 544;
    if (x[4]) s = s + (yi <<< 4);
    if (x[5]) s = s - (yi <<< 5);
    return 12'(s);
  endfunction

  function automatic logic [9:0] exp_pin(input logic [5:0] x, input logic [5:0] y);
    int yi;
    yi = $signed(y);
    return 10'(int'(x[3:0]) * yi + 544);
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [5:0] av, input logic [5:0] bv);
    wait_ready();
    in_valid = 1'b1;
    a = av;
    b = bv;
    step();
    in_valid = 1'b0;
    chk("accept_a_out", 32'(a_out), 32'(av));
    chk("accept_b_out", 32'(b_out), 32'(bv));
    chk("accum_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic expect_done(input logic [9:0] ep);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("accum_out_valid", 32'(out_valid), 32'd0);
    end
    step();
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_pin", 32'(pin), 32'(ep));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [5:0] av, input logic [5:0] bv, input logic [9:0] ep,
                     input logic [11:0] ep12);
    send(av, bv);
    expect_done(ep);
    chk("multb_p", 32'(multb(a_out, b_out, pin)), 32'(ep12));
    release_out();
  endtask

  initial begin
    logic [5:0] ra, rb;
    int         hold;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_pin", 32'(pin), 32'd0);
    chk("reset_a_out", 32'(a_out), 32'd0);
    chk("reset_b_out", 32'(b_out), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-computed partial sums and products.
    run(6'h01, 6'h01, 10'd545, 12'h001);
    run(6'h3F, 6'h3F, 10'd529, 12'h001);
    run(6'h20, 6'h1F, 10'd544, 12'hC20);
    run(6'h0F, 6'h1F, 10'd1009, 12'h1D1);
    run(6'h0F, 6'h20, 10'd64, 12'hE20);

    // Backpressure in DONE with a new pair waiting on the input.
    send(6'h05, 6'h03);
    expect_done(10'd559);
    in_valid = 1'b1;
    a = 6'h07;
    b = 6'h02;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_pin", 32'(pin), 32'd559);
      chk("hold_a_out", 32'(a_out), 32'd5);
      chk("hold_b_out", 32'(b_out), 32'd3);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("handoff_out_valid", 32'(out_valid), 32'd0);
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
    chk("handoff_a_out", 32'(a_out), 32'd5);
    step();
    in_valid = 1'b0;
    chk("late_accept_a_out", 32'(a_out), 32'd7);
    chk("late_accept_b_out", 32'(b_out), 32'd2);
    expect_done(10'd558);
    release_out();

    // Reset in the middle of accumulation discards the pair.
    send(6'h0A, 6'h05);
    step();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_pin", 32'(pin), 32'd0);
    chk("mid_rst_a_out", 32'(a_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    run(6'h02, 6'h3D, 10'd538, 12'hFFA);

    // Random pairs with random downstream stalls.
    for (int n = 0; n < 40; n++) begin
      ra = 6'($urandom);
      rb = 6'($urandom);
      send(ra, rb);
      expect_done(exp_pin(ra, rb));
      hold = int'($urandom_range(0, 3));
      for (int i = 0; i < hold; i++) begin
        step();
        chk("rand_hold_valid", 32'(out_valid), 32'd1);
      end
      chk("rand_multb_p", 32'(multb(a_out, b_out, pin)), 32'(prod(ra, rb)));
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
